// File: rtl/relu_act_unit.sv
// Two-stage activation pipeline: per-channel activation + rounding shift, then clip and
// saturation to the output width, with a sticky-saturating count of saturated beats.
module relu_act_unit #(
    parameter int unsigned CH         = 6,
    parameter int unsigned WDI        = 9,
    parameter int unsigned WDO        = 8,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned SHW        = 4,
    parameter int unsigned CNTW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*WDI-1:0]   in_data,
    input  logic                in_last,
    input  logic [1:0]          cfg_mode,
    input  logic [SHW-1:0]      cfg_shift,
    input  logic [WDO-1:0]      cfg_clip,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*WDO-1:0]   out_data,
    output logic                out_last,
    output logic [CNTW-1:0]     sat_cnt,
    input  logic                cnt_clr
);

    typedef enum logic [1:0] {ModeBypass, ModeRelu, ModeLeaky, ModeClip} mode_e;

    // Stage-1 result width; the rounding sum uses a wider scratch so any shift is exact.
    localparam int unsigned Wr = WDI + 1;
    localparam int unsigned Wa = WDI + (1 << SHW) + 1;
    localparam logic signed [Wa-1:0] One   = Wa'(1);
    localparam logic signed [Wr-1:0] SatHi = Wr'((1 << (WDO - 1)) - 1);
    localparam logic signed [Wr-1:0] SatLo = ~SatHi;

    logic                 s1_valid_q;
    logic [CH*Wr-1:0]     s1_r_d, s1_r_q;
    mode_e                s1_mode_q;
    logic [WDO-1:0]       s1_clip_q;
    logic                 s1_last_q;

    logic                 s2_valid_q;
    logic [CH*WDO-1:0]    s2_data_d, s2_data_q;
    logic                 s2_last_q;
    logic                 s2_sat_d, s2_sat_q;

    logic                 s1_adv, in_fire, out_fire;

    logic signed [Wa-1:0] act [CH];
    logic signed [Wa-1:0] rnd [CH];
    logic signed [Wr-1:0] rv  [CH];
    logic signed [Wr-1:0] clip_v;

    assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_r_d = '0;
        for (int c = 0; c < CH; c++) begin
            act[c] = Wa'($signed(in_data[c*WDI +: WDI]));
            case (mode_e'(cfg_mode))
                ModeBypass: ;
                ModeLeaky:  if (act[c] < 0) act[c] = act[c] >>> LEAK_SHIFT;
                default:    if (act[c] < 0) act[c] = '0;
            endcase
            if (cfg_shift == '0) begin
                rnd[c] = act[c];
            end else begin
                rnd[c] = (act[c] + (One <<< (cfg_shift - 1'b1))) >>> cfg_shift;
            end
            s1_r_d[c*Wr +: Wr] = rnd[c][Wr-1:0];
        end
    end

    // Clip to the configured ceiling is not a saturation event; only range limiting is.
    always_comb begin
        s2_data_d = '0;
        s2_sat_d  = 1'b0;
        clip_v    = Wr'($signed(s1_clip_q));
        for (int c = 0; c < CH; c++) begin
            rv[c] = $signed(s1_r_q[c*Wr +: Wr]);
            if (s1_mode_q == ModeClip && rv[c] > clip_v) rv[c] = clip_v;
            if (rv[c] > SatHi) begin
                rv[c]    = SatHi;
                s2_sat_d = 1'b1;
            end else if (rv[c] < SatLo) begin
                rv[c]    = SatLo;
                s2_sat_d = 1'b1;
            end
            s2_data_d[c*WDO +: WDO] = rv[c][WDO-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_mode_q  <= ModeBypass;
            s1_clip_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
            s2_sat_q   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_r_q     <= s1_r_d;
                s1_mode_q  <= mode_e'(cfg_mode);
                s1_clip_q  <= cfg_clip;
                s1_last_q  <= in_last;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid_q <= 1'b1;
                s2_data_q  <= s2_data_d;
                s2_last_q  <= s1_last_q;
                s2_sat_q   <= s2_sat_d;
            end else if (out_fire) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_fire && s2_sat_q && sat_cnt != '1) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;

endmodule

// File: tb/tb_relu_act_unit.sv
// Bench for relu_act_unit: directed vectors, backpressure, reset/clear, and random traffic
// checked against an integer-arithmetic reference model.
module tb_relu_act_unit;

    localparam int CH  = 6;
    localparam int WDI = 9;
    localparam int WDO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [CH*WDI-1:0]   in_data;
    logic                in_last;
    logic [1:0]          cfg_mode;
    logic [3:0]          cfg_shift;
    logic [WDO-1:0]      cfg_clip;
    logic                out_valid;
    logic                out_ready;
    logic [CH*WDO-1:0]   out_data;
    logic                out_last;
    logic [15:0]         sat_cnt;
    logic                cnt_clr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [CH*WDO-1:0] d;
        logic              last;
        logic              sat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    relu_act_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cfg_mode  (cfg_mode),
        .cfg_shift (cfg_shift),
        .cfg_clip  (cfg_clip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_cnt   (sat_cnt),
        .cnt_clr   (cnt_clr)
    );

    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic void model(input logic [CH*WDI-1:0] din, input logic [1:0] m,
                                  input logic [3:0] s, input logic [WDO-1:0] clip,
                                  output logic [CH*WDO-1:0] dout, output logic sat);
        int x, a, r, cl;
        logic [31:0] rb;
        dout = '0;
        sat  = 1'b0;
        cl   = int'($signed(clip));
        for (int c = 0; c < CH; c++) begin
            x = int'($signed(din[c*WDI +: WDI]));
            a = x;
            if (m != 2'd0 && x < 0) a = (m == 2'd2) ? fdiv(x, 8) : 0;
            r = (s == 4'd0) ? a : fdiv(a + (1 << (s - 1)), 1 << s);
            if (m == 2'd3 && r > cl) r = cl;
            if (r > 127) begin
                r = 127; sat = 1'b1;
            end else if (r < -128) begin
                r = -128; sat = 1'b1;
            end
            rb = r;
            dout[c*WDO +: WDO] = rb[WDO-1:0];
        end
    endfunction

    task automatic test_reset;
        in_valid = 0; in_data = '0; in_last = 0; cfg_mode = 0; cfg_shift = 0; cfg_clip = 0;
        out_ready = 0; cnt_clr = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
        total++; if (sat_cnt !== 16'd0) $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); else passed++;
        rst = 0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_vectors;
        int vin [4][6];
        int vout[4][6];
        logic [1:0] vm[4];
        logic [3:0] vs[4];
        logic [CH*WDI-1:0] din;
        logic [CH*WDO-1:0] dexp;
        vin  = '{'{-5, 100, 255, 0, -256, 127}, '{-16, -1, 40, -256, 0, -9},
                 '{6, 5, -6, -256, 255, 1},     '{200, -3, 4, 6, 7, 255}};
        vout = '{'{0, 100, 127, 0, 0, 127},     '{-2, -1, 40, -32, 0, -2},
                 '{2, 1, -1, -64, 64, 0},       '{6, 0, 4, 6, 6, 6}};
        vm = '{2'd1, 2'd2, 2'd0, 2'd3};
        vs = '{4'd0, 4'd0, 4'd2, 4'd0};
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < CH; c++) begin
                din[c*WDI +: WDI]  = WDI'(vin[i][c]);
                dexp[c*WDO +: WDO] = WDO'(vout[i][c]);
            end
            in_data = din; cfg_mode = vm[i]; cfg_shift = vs[i]; cfg_clip = 8'd6;
            in_last = i[0]; in_valid = 1; out_ready = 1;
            total++; if (in_ready !== 1'b1) $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); else passed++;
            @(posedge clk); #1;
            // Config changes after the handshake must not affect the accepted beat.
            in_valid = 0; cfg_mode = ~vm[i]; cfg_shift = 4'd5; cfg_clip = 8'd1;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) $display("FAIL vec%0d_valid got %b want 1", i, out_valid); else passed++;
            total++; if (out_data !== dexp) $display("FAIL vec%0d_data got %h want %h", i, out_data, dexp); else passed++;
            total++; if (out_last !== i[0]) $display("FAIL vec%0d_last got %b want %b", i, out_last, i[0]); else passed++;
            @(posedge clk); #1;
            total++; if (sat_cnt !== 16'd1) $display("FAIL vec%0d_sat_cnt got %0d want 1", i, sat_cnt); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [CH*WDI-1:0] bd[4];
        logic [CH*WDO-1:0] be[4];
        logic bs;
        int acc, got, cyc, unstable;
        cfg_mode = 2'd1; cfg_shift = 4'd1; cfg_clip = 8'd0;
        for (int k = 0; k < 4; k++) begin
            bd[k] = (CH*WDI)'({$urandom, $urandom});
            model(bd[k], 2'd1, 4'd1, 8'd0, be[k], bs);
        end
        out_ready = 0; acc = 0; unstable = 0;
        for (cyc = 0; cyc < 6; cyc++) begin
            in_valid = 1; in_data = bd[acc]; in_last = acc[0];
            @(negedge clk);
            if (out_valid && (out_data !== be[0] || out_last !== 1'b0)) unstable++;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        total++; if (acc !== 2) $display("FAIL b2b_accepted got %0d want 2", acc); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b1 || out_data !== be[0]) $display("FAIL b2b_hold got %b/%h want 1/%h", out_valid, out_data, be[0]); else passed++;
        total++; if (unstable !== 0) $display("FAIL b2b_stable got %0d changes want 0", unstable); else passed++;
        out_ready = 1; got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            if (acc < 4) begin
                in_valid = 1; in_data = bd[acc]; in_last = acc[0];
            end else begin
                in_valid = 0;
            end
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== be[got] || out_last !== got[0])
                    $display("FAIL b2b_beat%0d got %h/%b want %h/%b", got, out_data, out_last, be[got], got[0]);
                else passed++;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 0;
        total++; if (got !== 4) $display("FAIL b2b_drain got %0d beats want 4", got); else passed++;
    endtask

    task automatic test_reset_mid;
        int stale;
        out_ready = 0; cfg_mode = 2'd0; cfg_shift = 4'd0;
        in_valid = 1; in_data = (CH*WDI)'({$urandom, $urandom}); in_last = 1;
        @(posedge clk); #1;
        in_data = (CH*WDI)'({$urandom, $urandom});
        @(posedge clk); #1;
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL rstmid_full got v=%b r=%b want 1/0", out_valid, in_ready); else passed++;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else passed++;
        total++; if (sat_cnt !== 16'd0) $display("FAIL rstmid_sat_cnt got %0d want 0", sat_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else passed++;
        out_ready = 1; stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++; if (stale !== 0) $display("FAIL rstmid_stale got %0d beats want 0", stale); else passed++;
    endtask

    task automatic test_cnt_clr;
        @(posedge clk); #1;
        cfg_mode = 2'd0; cfg_shift = 4'd0; out_ready = 1;
        in_data = {CH{9'd255}}; in_valid = 1;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (sat_cnt !== 16'd1) $display("FAIL clr_pre got %0d want 1", sat_cnt); else passed++;
        in_valid = 1;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        cnt_clr = 1;
        total++; if (out_valid !== 1'b1) $display("FAIL clr_beat_valid got %b want 1", out_valid); else passed++;
        @(posedge clk); #1;
        cnt_clr = 0;
        total++; if (sat_cnt !== 16'd0) $display("FAIL clr_coincident got %0d want 0", sat_cnt); else passed++;
    endtask

    task automatic test_random;
        exp_t e;
        int exp_cnt, cyc;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; sb.delete(); exp_cnt = 0;
        for (cyc = 0; cyc < 400 + 20; cyc++) begin
            if (cyc < 400) begin
                in_valid  = ($urandom % 10) < 7;
                in_data   = (CH*WDI)'({$urandom, $urandom});
                cfg_mode  = 2'($urandom);
                cfg_shift = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
                cfg_clip  = 8'($urandom_range(0, 127));
                in_last   = 1'($urandom);
                out_ready = ($urandom % 10) < 7;
            end else begin
                in_valid = 0; out_ready = 1;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_unexpected_beat got %h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_last !== e.last)
                        $display("FAIL rand_beat got %h/%b want %h/%b", out_data, out_last, e.d, e.last);
                    else passed++;
                    if (e.sat && exp_cnt < 65535) exp_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                model(in_data, cfg_mode, cfg_shift, cfg_clip, e.d, e.sat);
                e.last = in_last;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        total++; if (sb.size() != 0) $display("FAIL rand_drain got %0d left want 0", sb.size()); else passed++;
        total++; if (sat_cnt !== 16'(exp_cnt)) $display("FAIL rand_sat_cnt got %0d want %0d", sat_cnt, exp_cnt); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        test_cnt_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
